qpu_exu_oitf: RTL
=================

# qpu_exu_oitf

Outstanding Instruction Track FIFO for the QPU execution unit. It records every long-pipe instruction that the dispatch stage issues, and tells dispatch about register hazards (RAW/WAW) and qubit-flag hazards against in-flight instructions. It releases entries in order as the long-pipe writeback commits them. It is the responder to the dispatch-side `disp_oitf_*` / `oitf*_match_disp*` interface.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `PTR_W`, 2: log2(`DEPTH`); must be consistent with `DEPTH`.
- `RFIDX_W`, `QPU_RFIDX_REAL_WIDTH`: register index width.
- `QUBIT_NUM`, `QPU_QUBIT_NUM`: qubit list width.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `dis_ena` in 1: allocate request; comes from `disp_oitf_ena`.
- `dis_ready` out 1: not full; goes to `disp_oitf_ready`.
- `dis_rs1en`, `dis_rs2en`, `dis_rdwen`, `dis_qfren` in 1 each: operand enables of the instruction at dispatch.
- `dis_rs1idx`, `dis_rs2idx`, `dis_rdidx` in `RFIDX_W` each: register indexes of the instruction at dispatch.
- `dis_qubitlist` in `QUBIT_NUM`: qubit list of the instruction at dispatch.
- `dis_ptr` out `PTR_W`: entry index that the current dispatch will occupy (the tail).
- `ret_ena` in 1: the long-pipe writeback commits the head entry.
- `ret_ptr` out `PTR_W`: head entry index.
- `ret_rdwen` out 1, `ret_rdidx` out `RFIDX_W`, `ret_qfren` out 1, `ret_qubitlist` out `QUBIT_NUM`: payload of the head entry.
- `oitf_empty` out 1: no valid entries.
- `oitfrd_match_disprs1`, `oitfrd_match_disprs2`, `oitfrd_match_disprd` out 1 each: register hazard flags.
- `oitfqf_match_dispql` out 1: qubit-flag hazard flag.

## Operation
Storage:
- Each entry holds `rdwen`, `rdidx`, `qfren` and `qubitlist`, plus a per-entry `vld` bit.
- Write and read pointers are `PTR_W+1` bits wide; the MSB is the wrap flag.
- `empty` = pointers equal.
- `full` = index bits equal and wrap flags differ.
- `dis_ready` = ~full. `oitf_empty` = empty.
- `dis_ptr` = write index bits. `ret_ptr` = read index bits.

Allocate (`dis_ena & ~full`):
- Write the payload into the entry at the write index.
- Set its `vld` bit.
- Increment the write pointer modulo 2·`DEPTH`.
- `dis_ena` while full is ignored: no write, no pointer change.

Retire (`ret_ena & ~empty`):
- Clear `vld` at the read index.
- Increment the read pointer.
- `ret_ena` while empty is ignored.

Head payload:
- `ret_*` outputs are the head entry's fields when not empty, and all zero when empty.

Hazard flags are combinational. They are evaluated only against registered `vld` entries; there is no bypass of same-cycle allocate or retire.
- `oitfrd_match_disprs1` = `dis_rs1en` & OR over i of (`vld[i]` & `rdwen[i]` & `rdidx[i]==dis_rs1idx`).
- `oitfrd_match_disprs2`: same form, using `rs2`.
- `oitfrd_match_disprd` = `dis_rdwen` & OR over i of (`vld[i]` & `rdwen[i]` & `rdidx[i]==dis_rdidx`).
- `oitfqf_match_dispql` = `dis_qfren` & OR over i of (`vld[i]` & `qfren[i]` & |(`qubitlist[i]` & `dis_qubitlist`)).

Simultaneous events:
- Allocate and retire in the same cycle, neither full nor empty: both take effect and occupancy is unchanged.
- When full: `dis_ready`=0, so only the retire happens; dispatch can allocate on the following cycle.
- When empty: only the allocate happens; `ret_ena` is ignored.
- `DEPTH`=N allows N outstanding entries; there is no reserved slot.

Reset (asynchronous, `rst_n`=0), effective immediately and also when asserted mid-operation:
- Pointers = 0 and all `vld` = 0.
- Hence `dis_ready`=1, `oitf_empty`=1, `dis_ptr`=`ret_ptr`=0.
- All `ret_*` = 0 and all match flags = 0.
- In-flight entries are discarded.
- Payload registers need no reset.

## Timing
- Allocation is registered: an entry written at edge k is visible in the match flags, `oitf_empty` and `dis_ready` from cycle k+1.
- Retirement is registered: an entry retired at edge k stops matching from cycle k+1; `ret_*` shows the next head in cycle k+1.
- Match flags are combinational, with zero-cycle latency from the `dis_*` inputs.
- `dis_ready` depends only on registered state (no combinational path from `dis_ena`/`ret_ena`), which prevents a loop through dispatch.
- Throughput: one allocate plus one retire per cycle.

## Test plan
- Reset, then idle: `oitf_empty`=1, `dis_ready`=1, all match flags=0. Drive `dis_rs1en`=1, `dis_rs1idx`=3: `oitfrd_match_disprs1`=0.
- Allocate `rdwen`=1, `rdidx`=5. Next cycle present `rs1idx`=5, `rs2idx`=5 (both enabled) and `rdidx`=5 with `rdwen`=1: all three register flags=1. Retire it: all three flags=0 the cycle after.
- `DEPTH`=4: four back-to-back allocates make `dis_ready`=0. A fifth `dis_ena` is ignored (`dis_ptr` stays 0). Retire plus `dis_ena` in the same cycle: only the retire occurs. Next cycle allocate succeeds and `dis_ptr` wraps 0→1.
- Allocate `qfren`=1, `qubitlist`=4'b0110. Present `dis_qfren`=1: with `dis_qubitlist`=4'b1000 the flag is 0; with 4'b0100 `oitfqf_match_dispql`=1; with `dis_qfren`=0 it is 0.
- At half occupancy, allocate and retire together for 10 cycles: occupancy is constant, `ret_rdidx` follows dispatch order, and pointers wrap correctly.
- Assert `rst_n`=0 mid-operation with 3 entries valid: `oitf_empty`=1 and all flags=0 immediately; after release the first allocate lands at `dis_ptr`=0.

Source files
------------

// File: rtl/qpu_exu_oitf.sv
// rtl/qpu_exu_oitf.sv - outstanding instruction track FIFO for the QPU long pipe
//
// Purpose: records long-pipe instructions issued by dispatch, flags RAW/WAW
// register hazards and qubit-flag hazards against in-flight entries, and
// releases entries in order as writeback commits them.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   dis_ena / dis_ready   allocate request / not-full
//   dis_rs1en..dis_qfren  operand enables of the dispatching instruction
//   dis_rs1idx..dis_rdidx register indexes of the dispatching instruction
//   dis_qubitlist         qubit list of the dispatching instruction
//   dis_ptr               entry the current dispatch will occupy (tail)
//   ret_ena / ret_ptr     commit head entry / head entry index
//   ret_rdwen..ret_qubitlist  head entry payload (zero when empty)
//   oitf_empty            no valid entries
//   oitfrd_match_*        register hazard flags
//   oitfqf_match_dispql   qubit-flag hazard flag
module qpu_exu_oitf #(
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2,
  parameter int RFIDX_W   = 5,
  parameter int QUBIT_NUM = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dis_ena,
  output logic                 dis_ready,
  input  logic                 dis_rs1en,
  input  logic                 dis_rs2en,
  input  logic                 dis_rdwen,
  input  logic                 dis_qfren,
  input  logic [RFIDX_W-1:0]   dis_rs1idx,
  input  logic [RFIDX_W-1:0]   dis_rs2idx,
  input  logic [RFIDX_W-1:0]   dis_rdidx,
  input  logic [QUBIT_NUM-1:0] dis_qubitlist,
  output logic [PTR_W-1:0]     dis_ptr,
  input  logic                 ret_ena,
  output logic [PTR_W-1:0]     ret_ptr,
  output logic                 ret_rdwen,
  output logic [RFIDX_W-1:0]   ret_rdidx,
  output logic                 ret_qfren,
  output logic [QUBIT_NUM-1:0] ret_qubitlist,
  output logic                 oitf_empty,
  output logic                 oitfrd_match_disprs1,
  output logic                 oitfrd_match_disprs2,
  output logic                 oitfrd_match_disprd,
  output logic                 oitfqf_match_dispql
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  // with all DEPTH slots in use.
  logic [PTR_W:0]     wptr_q, wptr_d;
  logic [PTR_W:0]     rptr_q, rptr_d;
  logic [DEPTH-1:0]   vld_q, vld_d;

  logic               rdwen_q     [DEPTH];
  logic               rdwen_d     [DEPTH];
  logic [RFIDX_W-1:0] rdidx_q     [DEPTH];
  logic [RFIDX_W-1:0] rdidx_d     [DEPTH];
  logic               qfren_q     [DEPTH];
  logic               qfren_d     [DEPTH];
  logic [QUBIT_NUM-1:0] qubitlist_q [DEPTH];
  logic [QUBIT_NUM-1:0] qubitlist_d [DEPTH];

  logic             full;
  logic             empty;
  logic             alloc;
  logic             retire;
  logic [PTR_W-1:0] widx;
  logic [PTR_W-1:0] ridx;

  always_comb begin
    widx   = wptr_q[PTR_W-1:0];
    ridx   = rptr_q[PTR_W-1:0];
    empty  = (wptr_q == rptr_q);
    full   = (widx == ridx) && (wptr_q[PTR_W] != rptr_q[PTR_W]);
    alloc  = dis_ena & ~full;
    retire = ret_ena & ~empty;

    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    vld_d       = vld_q;
    rdwen_d     = rdwen_q;
    rdidx_d     = rdidx_q;
    qfren_d     = qfren_q;
    qubitlist_d = qubitlist_q;

    // Allocate and retire never target the same slot: when both are
    // allowed the FIFO is neither full nor empty, so the indices differ.
    if (alloc) begin
      vld_d[widx]       = 1'b1;
      rdwen_d[widx]     = dis_rdwen;
      rdidx_d[widx]     = dis_rdidx;
      qfren_d[widx]     = dis_qfren;
      qubitlist_d[widx] = dis_qubitlist;
      wptr_d            = wptr_q + PTR_ONE;
    end
    if (retire) begin
      vld_d[ridx] = 1'b0;
      rptr_d      = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      vld_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      vld_q  <= vld_d;
    end
  end

  // Payload is qualified by vld everywhere it is observed, so it needs no reset.
  always_ff @(posedge clk) begin
    rdwen_q     <= rdwen_d;
    rdidx_q     <= rdidx_d;
    qfren_q     <= qfren_d;
    qubitlist_q <= qubitlist_d;
  end

  always_comb begin
    dis_ready  = ~full;
    oitf_empty = empty;
    dis_ptr    = widx;
    ret_ptr    = ridx;

    ret_rdwen     = 1'b0;
    ret_rdidx     = '0;
    ret_qfren     = 1'b0;
    ret_qubitlist = '0;
    if (!empty) begin
      ret_rdwen     = rdwen_q[ridx];
      ret_rdidx     = rdidx_q[ridx];
      ret_qfren     = qfren_q[ridx];
      ret_qubitlist = qubitlist_q[ridx];
    end
  end

  // Hazards look only at registered entries; a same-cycle allocate or
  // retire is not bypassed.
  logic hit_rs1, hit_rs2, hit_rd, hit_ql;

  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    hit_rd  = 1'b0;
    hit_ql  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && rdwen_q[i]) begin
        if (rdidx_q[i] == dis_rs1idx) hit_rs1 = 1'b1;
        if (rdidx_q[i] == dis_rs2idx) hit_rs2 = 1'b1;
        if (rdidx_q[i] == dis_rdidx)  hit_rd  = 1'b1;
      end
      if (vld_q[i] && qfren_q[i] && |(qubitlist_q[i] & dis_qubitlist)) begin
        hit_ql = 1'b1;
      end
    end
    oitfrd_match_disprs1 = dis_rs1en & hit_rs1;
    oitfrd_match_disprs2 = dis_rs2en & hit_rs2;
    oitfrd_match_disprd  = dis_rdwen & hit_rd;
    oitfqf_match_dispql  = dis_qfren & hit_ql;
  end

endmodule
